// File: rtl/booth_mul_4bits.sv
// Radix-2 Booth multiplier, 4x4 signed -> 8-bit signed, one iteration per cycle.
// Optional BOOTH_MUL_ZERO_SKIP_EN: a zero operand bypasses the iterations and completes in one cycle.

module add_sub_4bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       m,
  output logic [3:0] s,
  output logic       v
);
  logic [3:0] bx;
  logic       c;

  always_comb begin
    bx     = b ^ {4{m}};
    {c, s} = {1'b0, a} + {1'b0, bx} + {4'b0000, m};
    v      = (a[3] == bx[3]) && (s[3] != a[3]);
  end
endmodule

module booth_mul_4bits (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] p
);
  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t     state_q, state_d;
  logic [3:0] acc_q, acc_d, q_q, q_d, m_q, m_d;
  logic       q1_q, q1_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] p_q, p_d;

  logic [3:0] sum;
  logic       ovf;
  logic       add_en;
  logic [3:0] acc_sum;
  logic       msb;

  // Mode follows Q[0]: pair 10 subtracts, 01 adds; 00/11 ignore the adder result.
  add_sub_4bits u_add_sub (
    .a(acc_q),
    .b(m_q),
    .m(q_q[0]),
    .s(sum),
    .v(ovf)
  );

  always_comb begin
    add_en  = q_q[0] ^ q1_q;
    acc_sum = add_en ? sum : acc_q;
    // True sign of the 5-bit result survives a 4-bit overflow (e.g. 0 - (-8)).
    msb     = add_en ? (sum[3] ^ ovf) : acc_q[3];
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q1_d    = q1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          acc_d   = 4'd0;
          q1_d    = 1'b0;
          cnt_d   = 2'd0;
          state_d = StRun;
`ifdef BOOTH_MUL_ZERO_SKIP_EN
          if (a == 4'd0 || b == 4'd0) begin
            p_d     = 8'h00;
            state_d = StDone;
          end
`endif
        end
      end
      StRun: begin
        acc_d = {msb, acc_sum[3:1]};
        q_d   = {acc_sum[0], q_q[3:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          p_d     = {msb, acc_sum[3:1], acc_sum[0], q_q[3:1]};
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= 4'd0;
      q_q     <= 4'd0;
      q1_q    <= 1'b0;
      m_q     <= 4'd0;
      cnt_q   <= 2'd0;
      p_q     <= 8'h00;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign p    = p_q;
endmodule

// File: tb/tb_booth_mul_4bits.sv
// Self-checking bench for booth_mul_4bits: latency/product model plus directed and random stimulus.
`timescale 1ns/1ps

module tb_booth_mul_4bits;
`ifdef BOOTH_MUL_ZERO_SKIP_EN
  localparam bit Skip = 1'b1;
`else
  localparam bit Skip = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic       busy, done;
  logic [7:0] p;

  int checks = 0;
  int errors = 0;
  int dcount = 0;

  booth_mul_4bits dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .p(p)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] prod(input logic [3:0] x, input logic [3:0] y);
    int xi, yi, r;
    xi = $signed(x);
    yi = $signed(y);
    r  = xi * yi;
    return r[7:0];
  endfunction

  function automatic int lat(input logic [3:0] x, input logic [3:0] y);
    return (Skip && (x == 4'd0 || y == 4'd0)) ? 1 : 5;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: cycles remaining until the block is idle again; product lands entering the done cycle.
  int         rem;
  logic [7:0] pend, m_p;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= 0;
      pend <= 8'h00;
      m_p  <= 8'h00;
    end else if (rem == 0) begin
      if (start) begin
        rem  <= lat(a, b);
        pend <= prod(a, b);
        if (lat(a, b) == 1) m_p <= 8'h00;
      end
    end else begin
      rem <= rem - 1;
      if (rem == 2) m_p <= pend;
    end
  end

  always @(negedge clk) begin
    check("busy", {31'd0, busy}, {31'd0, rem != 0});
    check("done", {31'd0, done}, {31'd0, rem == 1});
    check("p", {24'd0, p}, {24'd0, m_p});
    if (done === 1'b1) dcount++;
  end

  // Called just after a posedge with the DUT idle; returns just after the DONE->IDLE edge.
  task automatic op(input logic [3:0] x, input logic [3:0] y, input logic [7:0] lit,
                    input string nm);
    int n;
    start = 1'b1;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 4'($urandom);
    b = 4'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 10);
    check({nm, "_p"}, {24'd0, p}, {24'd0, lit});
    check({nm, "_lat"}, n, lat(x, y));
    check({nm, "_busy"}, {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_p", {24'd0, p}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    op(4'd3, 4'd5, 8'h0F, "3x5");
    op(4'h8, 4'h8, 8'h40, "m8xm8");
    op(4'h8, 4'd7, 8'hC8, "m8x7");
    op(4'd7, 4'hF, 8'hF9, "7xm1");
    op(4'd0, 4'hD, 8'h00, "0xm3");

    // Repeated start during RUN must be dropped.
    d0 = dcount;
    start = 1'b1; a = 4'd2; b = 4'd3;
    @(posedge clk); #1;
    a = 4'd1; b = 4'd1;
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("drop_p", {24'd0, p}, 32'h06);
    repeat (6) begin @(posedge clk); #1; end
    check("drop_ndone", dcount - d0, 1);

    // Reset in the middle of a run.
    d0 = dcount;
    start = 1'b1; a = 4'd5; b = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_p", {24'd0, p}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check("mid_rst_ndone", dcount - d0, 0);
    op(4'd2, 4'd2, 8'h04, "2x2");

    // Exhaustive sweep at minimum start spacing.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] ab;
      ab = 8'(i);
      op(ab[7:4], ab[3:0], prod(ab[7:4], ab[3:0]), "sweep");
    end

    // Free-running random traffic, checked only by the model.
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 3) == 0);
      a = 4'($urandom);
      b = 4'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (8) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/booth_mul_4bits.md
BOOTH_MUL_4BITS -- requirements
Module: booth_mul_4bits

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 4 bits signed and product width at 8 bits signed.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 a  input  4  multiplicand, two's complement; captured when start is accepted.
REQ-006 b  input  4  multiplier, two's complement; captured when start is accepted.
REQ-007 busy  output  1  high in RUN and DONE, low in IDLE.
REQ-008 done  output  1  one-cycle pulse, high only in DONE.
REQ-009 p  output  8  signed product a*b; valid while done=1, held until the next accepted start.

Function
REQ-010 The block SHALL implement radix-2 Booth multiplication with one add_sub_4bits instance as its only adder/subtractor.
REQ-011 Registers: ACC[3:0], Q[3:0], Q_1, M[3:0], 2-bit iteration count CNT, state {IDLE, RUN, DONE}.
REQ-012 IDLE with start=1 at an edge: M<=a, Q<=b, ACC<=0, Q_1<=0, CNT<=0, state<=RUN; start=0 keeps IDLE.
REQ-013 Each RUN cycle SHALL perform one iteration: {Q[0],Q_1}=01 -> ACC+M (M port=0); 10 -> ACC-M (M port=1); 00/11 -> no add, ACC unchanged.
REQ-014 After the add/sub, {ACC,Q,Q_1} SHALL shift right arithmetically by one; the bit shifted into ACC[3] SHALL be S[3] XOR V (true 5-bit sign), or ACC[3] when no add occurs.
REQ-015 In RUN, CNT SHALL increment each cycle; when CNT=3, p<={ACC,Q} after that cycle's shift, and state<=DONE.
REQ-016 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-017 Latency: start accepted at edge k -> done=1 during the cycle after edge k+4; a new start is accepted no earlier than edge k+6.
REQ-018 start in RUN or DONE SHALL be ignored, with no effect on a, b capture or on the result.
REQ-019 a and b changing after capture SHALL NOT affect the product in progress.
REQ-020 Boundary: a=-8 with b negative (ACC-M overflows 4 bits) SHALL yield the correct product via REQ-014; -8*-8 = +64.

Reset
REQ-021 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, p=8'h00, and ACC, Q, Q_1, M, CNT to 0, regardless of clk.
REQ-022 Reset mid-RUN SHALL abandon the operation with no done pulse; the first start after rst_n rises SHALL behave per REQ-012.

Configuration
REQ-023 Macro BOOTH_MUL_ZERO_SKIP_EN SHALL select zero-operand bypass.
REQ-024 With BOOTH_MUL_ZERO_SKIP_EN defined, an accepted start with a==0 or b==0 SHALL go directly IDLE->DONE with p<=0, so done is high during the cycle after the start edge.
REQ-025 Without BOOTH_MUL_ZERO_SKIP_EN, every accepted start SHALL take the full 4-iteration path per REQ-017.

Verification
REQ-026 a=3, b=5, start pulse -> p=8'h0F, done high for one cycle, 5 cycles after the start edge, busy high through DONE.
REQ-027 a=-8, b=-8 -> p=8'h40; a=-8, b=7 -> p=8'hC8; a=7, b=-1 -> p=8'hF9.
REQ-028 Exhaustive sweep over all 256 (a,b) pairs, including back-to-back starts at the minimum spacing -> p equals signed a*b every time.
REQ-029 start re-asserted with a=1, b=1 during RUN of 2*3 -> p=8'h06, exactly one done pulse, and the second request is dropped.
REQ-030 rst_n low 2 cycles after start of 5*5 -> p=0, busy=0, no done; a new start with 2*2 -> p=8'h04.
REQ-031 a=0, b=-3 -> p=0: done 1 cycle after the start edge with BOOTH_MUL_ZERO_SKIP_EN defined, 5 cycles after without it.
